sd_cmd_framer: RTL and testbench
================================

# sd_cmd_framer

Command-level front end for the SD-card SPI path. It accepts an SD command index and 32-bit argument, builds the 6-byte SPI-mode command frame with CRC7, and drives the byte-level SPI controller to transmit it. It then has the controller clock out a window of response bytes and returns the first R1 byte found, or a timeout. It sits directly upstream of the SPI controller and supplies its `data_in` byte from the controller's `address` output.

## Interface
Parameters:
- `MEMORY_SIZE_IN_BYTES`, default 64: matches the SPI controller. `AW = $clog2(MEMORY_SIZE_IN_BYTES)`.
- `RESP_WINDOW`, default 8: number of bytes read while polling for R1. Legal range is 1..MEMORY_SIZE_IN_BYTES.

Ports:
- `clk` input, 1: single clock; all logic on posedge.
- `rst` input, 1: asynchronous, active-high reset.
- `cmd_start` input, 1: request, sampled only in IDLE.
- `cmd_index` input, 6: SD command number, latched on accept.
- `cmd_arg` input, 32: command argument, latched on accept.
- `busy` output, 1: high from accept until the cycle after `rsp_valid`.
- `rsp_valid` output, 1: one-cycle pulse at completion.
- `rsp_r1` output, 8: captured R1 byte. Holds its value until the next accept. Reads 0xFF on timeout.
- `rsp_timeout` output, 1: qualifies `rsp_valid`; set when no byte with bit7=0 was seen.
- `spi_start` output, 1: one-cycle start pulse to the controller.
- `spi_op` output, 1: 1 = write, 0 = read. Held stable while busy.
- `spi_size` output, AW: last byte index, i.e. transfer length minus 1.
- `spi_data_in` output, 8: frame byte selected by `spi_address`. Combinational.
- `spi_address` input, AW: byte index from the controller.
- `spi_data_out` input, 8: received byte.
- `spi_wr` input, 1: `spi_data_out` holds a complete byte this cycle.
- `spi_done` input, 1: transfer-complete pulse.

## Operation
- Frame bytes, indexed by `spi_address`:
  - 0 = `{2'b01, cmd_index}`
  - 1..4 = `cmd_arg[31:24]` .. `cmd_arg[7:0]`
  - 5 = `{crc7, 1'b1}`
  - any other address = 0xFF
- CRC7 uses polynomial x^7+x^3+1 with initial value 0. It is computed serially, MSB first, over the 40 bits of bytes 0..4, at one bit per clock.
- The FSM has states IDLE, CRC, TX_START, TX_WAIT, RX_START, RX_WAIT, RESP.
- IDLE:
  - `busy` = 0.
  - On `cmd_start`=1: latch index and arg, clear the CRC register, set bit counter to 39, clear the found flag, set `rsp_r1` to 0xFF, go to CRC.
- CRC:
  - Shift one bit per cycle.
  - When the counter reaches 0 (40th cycle), latch crc7 and go to TX_START.
- TX_START:
  - `spi_start`=1, `spi_op`=1, `spi_size`=5.
  - Next state is TX_WAIT.
- TX_WAIT:
  - `spi_op`=1, `spi_size`=5.
  - On `spi_done`, go to RX_START.
- RX_START:
  - `spi_start`=1, `spi_op`=0, `spi_size`=RESP_WINDOW-1.
  - Next state is RX_WAIT.
- RX_WAIT:
  - On each `spi_wr`, if not yet found and `spi_data_out[7]`==0: latch `rsp_r1`, set found.
  - Later bytes are ignored.
  - On `spi_done`, go to RESP. If `spi_wr` and `spi_done` coincide, the byte is evaluated first.
- RESP:
  - `rsp_valid`=1, `rsp_timeout`=!found.
  - Next state is IDLE.
- `cmd_start` outside IDLE is ignored. It is not queued.
- `spi_done` outside TX_WAIT/RX_WAIT is ignored. `spi_wr` outside RX_WAIT is ignored.
- Reset mid-operation:
  - All state returns to IDLE immediately.
  - No `spi_start` or `rsp_valid` is emitted after reset release until a new accept.
  - An in-flight controller transfer is the responsibility of the controller's own reset.

## Timing
- Reset values:
  - `busy`=0, `rsp_valid`=0, `rsp_r1`=0xFF, `rsp_timeout`=0.
  - `spi_start`=0, `spi_op`=0, `spi_size`=0.
  - CRC register 0.
- All outputs are registered except `spi_data_in`. That output is combinational from `spi_address` plus latched registers, so it is valid in the same cycle the controller presents the address.
- Accept at edge N: `busy`=1 from N+1. CRC occupies N+1..N+40. `spi_start` is high during cycle N+41.
- TX_WAIT → RX_START takes 1 cycle after `spi_done`. `spi_start` for the read is high in the cycle following RX_START entry.
- `rsp_valid` is high the cycle after the read `spi_done` is sampled. `busy` falls together with the `rsp_valid` deassertion.
- Fixed overhead is 44 cycles plus the controller transfer times.
- Back-to-back: a new `cmd_start` is accepted in the first IDLE cycle after RESP.

## Test plan
- CMD0, arg 0x00000000:
  - TX bytes are 40 00 00 00 00 95.
  - Read window returns FF FF 01 FF… → `rsp_valid` with `rsp_r1`=0x01, `rsp_timeout`=0.
- CMD8, arg 0x000001AA:
  - TX bytes are 48 00 00 01 AA 87.
  - Response 05 on the first byte → `rsp_r1`=0x05. Later bytes 00 are not captured.
- Timeout: all window bytes are 0xFF → `rsp_valid`=1, `rsp_timeout`=1, `rsp_r1`=0xFF.
- `cmd_start` pulsed while in CRC and in TX_WAIT → ignored. The frame of the original command is unchanged, with a single `rsp_valid`.
- `rst` asserted during RX_WAIT:
  - All outputs go to reset values asynchronously.
  - After release, no `rsp_valid` appears.
  - A new CMD17 arg 0x00000200 produces TX bytes 51 00 00 02 00 with correct CRC.
- Last window byte 0x00 with `spi_wr` and `spi_done` in the same cycle → `rsp_r1`=0x00, `rsp_timeout`=0.

Source files
------------

// File: rtl/sd_cmd_framer.sv
// SD-card SPI-mode command framer: builds the 6-byte command frame with CRC7,
// drives the byte-level SPI controller through a write and a response read.
module sd_cmd_framer #(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int RESP_WINDOW          = 8,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic [5:0]    cmd_index,
  input  logic [31:0]   cmd_arg,
  output logic          busy,
  output logic          rsp_valid,
  output logic [7:0]    rsp_r1,
  output logic          rsp_timeout,
  output logic          spi_start,
  output logic          spi_op,
  output logic [AW-1:0] spi_size,
  output logic [7:0]    spi_data_in,
  input  logic [AW-1:0] spi_address,
  input  logic [7:0]    spi_data_out,
  input  logic          spi_wr,
  input  logic          spi_done
);

  typedef enum logic [2:0] {
    IDLE,
    CRC,
    TX_START,
    TX_WAIT,
    RX_START,
    RX_WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc_q, crc_d;
  logic [6:0]    crc7_q, crc7_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          found_q, found_d;
  logic [7:0]    r1_q, r1_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          start_q, start_d;
  logic          op_q, op_d;
  logic [AW-1:0] size_q, size_d;

  logic [39:0]   frameBits;
  logic          crcFeedback;
  logic [6:0]    crcShifted;

  // The first five frame bytes as one MSB-first bit stream feeding the CRC.
  assign frameBits   = {2'b01, idx_q, arg_q};
  assign crcFeedback = frameBits[cnt_q] ^ crc_q[6];
  assign crcShifted  = {crc_q[5:0], 1'b0} ^ (crcFeedback ? 7'h09 : 7'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      arg_q     <= '0;
      crc_q     <= '0;
      crc7_q    <= '0;
      cnt_q     <= '0;
      found_q   <= 1'b0;
      r1_q      <= 8'hFF;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      op_q      <= 1'b0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      crc7_q    <= crc7_d;
      cnt_q     <= cnt_d;
      found_q   <= found_d;
      r1_q      <= r1_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      op_q      <= op_d;
      size_q    <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    crc_d   = crc_q;
    crc7_d  = crc7_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    r1_d    = r1_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          idx_d   = cmd_index;
          arg_d   = cmd_arg;
          crc_d   = '0;
          cnt_d   = 6'd39;
          found_d = 1'b0;
          r1_d    = 8'hFF;
          state_d = CRC;
        end
      end
      CRC: begin
        crc_d = crcShifted;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) begin
          crc7_d  = crcShifted;
          state_d = TX_START;
        end
      end
      TX_START: state_d = TX_WAIT;
      TX_WAIT: begin
        if (spi_done) state_d = RX_START;
      end
      RX_START: state_d = RX_WAIT;
      RX_WAIT: begin
        // A byte arriving together with done is still considered for R1.
        if (spi_wr && !found_q && !spi_data_out[7]) begin
          r1_d    = spi_data_out;
          found_d = 1'b1;
        end
        if (spi_done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d    = (state_d != IDLE);
    start_d   = (state_d == TX_START) || (state_d == RX_START);
    valid_d   = (state_d == RESP);
    timeout_d = (state_d == RESP) && !found_d;
    op_d      = (state_d == TX_START) || (state_d == TX_WAIT);
    size_d    = size_q;
    if ((state_d == TX_START) || (state_d == TX_WAIT)) begin
      size_d = AW'(5);
    end else if ((state_d == RX_START) || (state_d == RX_WAIT)) begin
      size_d = AW'(RESP_WINDOW - 1);
    end
  end

  always_comb begin
    spi_data_in = 8'hFF;
    case (spi_address)
      AW'(0):  spi_data_in = {2'b01, idx_q};
      AW'(1):  spi_data_in = arg_q[31:24];
      AW'(2):  spi_data_in = arg_q[23:16];
      AW'(3):  spi_data_in = arg_q[15:8];
      AW'(4):  spi_data_in = arg_q[7:0];
      AW'(5):  spi_data_in = {crc7_q, 1'b1};
      default: spi_data_in = 8'hFF;
    endcase
  end

  assign busy        = busy_q;
  assign rsp_valid   = valid_q;
  assign rsp_r1      = r1_q;
  assign rsp_timeout = timeout_q;
  assign spi_start   = start_q;
  assign spi_op      = op_q;
  assign spi_size    = size_q;

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer: the bench plays the SPI controller,
// capturing the transmitted frame and feeding response windows.
module tb_sd_cmd_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        rsp_valid;
  logic [7:0]  rsp_r1;
  logic        rsp_timeout;
  logic        spi_start;
  logic        spi_op;
  logic [5:0]  spi_size;
  logic [7:0]  spi_data_in;
  logic [5:0]  spi_address;
  logic [7:0]  spi_data_out;
  logic        spi_wr;
  logic        spi_done;

  int checks = 0;
  int fails  = 0;
  int validCount = 0;
  int startCount = 0;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  crcByte;
    logic [63:0] resp;
    logic        coincide;
    logic [7:0]  expR1;
    logic        expTimeout;
  } vec_t;

  vec_t vecs [5];
  vec_t v17;

  sd_cmd_framer #(.MEMORY_SIZE_IN_BYTES(64), .RESP_WINDOW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_r1       (rsp_r1),
    .rsp_timeout  (rsp_timeout),
    .spi_start    (spi_start),
    .spi_op       (spi_op),
    .spi_size     (spi_size),
    .spi_data_in  (spi_data_in),
    .spi_address  (spi_address),
    .spi_data_out (spi_data_out),
    .spi_wr       (spi_wr),
    .spi_done     (spi_done)
  );

  always #5 clk = ~clk;

  // Pulse counters used to catch spurious or repeated starts and completions.
  always @(negedge clk) begin
    if (rsp_valid) validCount++;
    if (spi_start) startCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] crc7Ref(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] f;
    logic [6:0]  c;
    logic        b;
    f = {2'b01, idx, arg};
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      b = f[i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (b) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  function automatic logic [7:0] expByte(input vec_t v, input int i);
    case (i)
      0:       return {2'b01, v.idx};
      1:       return v.arg[31:24];
      2:       return v.arg[23:16];
      3:       return v.arg[15:8];
      4:       return v.arg[7:0];
      5:       return v.crcByte;
      default: return 8'hFF;
    endcase
  endfunction

  // Runs one full command; must be called right after a negedge in IDLE.
  task automatic applyStimulus(input vec_t v, input bit injectStarts);
    int  cnt;
    bit  seen;
    int  validBefore;
    int  startBefore;
    validBefore = validCount;
    startBefore = startCount;
    cmd_index = v.idx;
    cmd_arg   = v.arg;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    checkOutput("busyAfterAccept", busy, 1);
    checkOutput("r1ClearedOnAccept", rsp_r1, 8'hFF);
    cnt  = 1;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      if (spi_start) begin
        seen = 1'b1;
      end else begin
        if (injectStarts && cnt == 10) begin
          cmd_index = 6'h3F;
          cmd_arg   = 32'hDEADBEEF;
          cmd_start = 1'b1;
        end else begin
          cmd_start = 1'b0;
        end
        @(negedge clk);
        cnt++;
      end
    end
    cmd_start = 1'b0;
    checkOutput("txStartLatency", cnt, 41);
    if (!seen) return;
    checkOutput("txOp", spi_op, 1);
    checkOutput("txSize", spi_size, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("txStartOneCycle", spi_start, 0);
      spi_address = 6'(i);
      #1;
      checkOutput($sformatf("txByte%0d", i), spi_data_in, expByte(v, i));
      cmd_start = injectStarts && (i == 2);
    end
    spi_address = 6'd6;
    #1;
    checkOutput("txBeyondFrame", spi_data_in, 8'hFF);
    @(negedge clk);
    cmd_start = 1'b0;
    spi_done  = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checkOutput("rxStart", spi_start, 1);
    checkOutput("rxOp", spi_op, 0);
    checkOutput("rxSize", spi_size, 7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      spi_address  = 6'(i);
      spi_data_out = v.resp[63-8*i -: 8];
      spi_wr       = 1'b1;
      if (i == 7 && v.coincide) spi_done = 1'b1;
    end
    @(negedge clk);
    spi_wr   = 1'b0;
    spi_done = 1'b0;
    if (!v.coincide) begin
      spi_done = 1'b1;
      @(negedge clk);
      spi_done = 1'b0;
    end
    checkOutput("rspValid", rsp_valid, 1);
    checkOutput("rspR1", rsp_r1, v.expR1);
    checkOutput("rspTimeout", rsp_timeout, v.expTimeout);
    checkOutput("busyDuringResp", busy, 1);
    @(negedge clk);
    checkOutput("rspValidPulse", rsp_valid, 0);
    checkOutput("busyFalls", busy, 0);
    checkOutput("r1Held", rsp_r1, v.expR1);
    checkOutput("validPulseCount", validCount - validBefore, 1);
    checkOutput("startPulseCount", startCount - startBefore, 2);
  endtask

  initial begin
    int cnt;
    int startBefore;
    int validBefore;
    rst          = 1'b1;
    cmd_start    = 1'b0;
    cmd_index    = '0;
    cmd_arg      = '0;
    spi_address  = '0;
    spi_data_out = 8'hFF;
    spi_wr       = 1'b0;
    spi_done     = 1'b0;
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetValid", rsp_valid, 0);
    checkOutput("resetR1", rsp_r1, 8'hFF);
    checkOutput("resetTimeout", rsp_timeout, 0);
    checkOutput("resetStart", spi_start, 0);
    checkOutput("resetOp", spi_op, 0);
    checkOutput("resetSize", spi_size, 0);
    spi_address = 6'd5;
    #1;
    checkOutput("resetCrcByte", spi_data_in, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{idx: 6'd0,  arg: 32'h00000000, crcByte: 8'h95,
                resp: 64'hFFFF01FFFFFFFFFF, coincide: 1'b0, expR1: 8'h01, expTimeout: 1'b0};
    vecs[1] = '{idx: 6'd8,  arg: 32'h000001AA, crcByte: 8'h87,
                resp: 64'h0500000000000000, coincide: 1'b0, expR1: 8'h05, expTimeout: 1'b0};
    vecs[2] = '{idx: 6'd58, arg: 32'h00000000, crcByte: crc7Ref(6'd58, 32'h0),
                resp: 64'hFFFFFFFFFFFFFFFF, coincide: 1'b0, expR1: 8'hFF, expTimeout: 1'b1};
    vecs[3] = '{idx: 6'd55, arg: 32'h00000000, crcByte: crc7Ref(6'd55, 32'h0),
                resp: 64'hFFFFFFFFFFFFFF00, coincide: 1'b1, expR1: 8'h00, expTimeout: 1'b0};
    vecs[4] = '{idx: 6'd41, arg: 32'h40000000, crcByte: crc7Ref(6'd41, 32'h40000000),
                resp: 64'hFFFF80FF7F01FFFF, coincide: 1'b0, expR1: 8'h7F, expTimeout: 1'b0};

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d: CMD%0d arg 0x%08h", i, vecs[i].idx, vecs[i].arg);
      applyStimulus(vecs[i], i == 4);
    end

    startBefore = startCount;
    validBefore = validCount;
    repeat (50) @(negedge clk);
    checkOutput("noQueuedStart", startCount - startBefore, 0);
    checkOutput("noExtraValid", validCount - validBefore, 0);

    // Reset in the middle of the response read.
    $display("[TB] reset during RX_WAIT");
    cmd_index = 6'd8;
    cmd_arg   = 32'h000001AA;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cnt = 0;
    while (!spi_start && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("rstSeqTxStart", spi_start, 1);
    repeat (4) @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checkOutput("rstSeqRxStart", spi_start, 1);
    @(negedge clk);
    spi_data_out = 8'hFF;
    spi_wr       = 1'b1;
    @(negedge clk);
    spi_wr = 1'b0;
    checkOutput("rstSeqBusyBefore", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstBusy", busy, 0);
    checkOutput("asyncRstValid", rsp_valid, 0);
    checkOutput("asyncRstR1", rsp_r1, 8'hFF);
    checkOutput("asyncRstTimeout", rsp_timeout, 0);
    checkOutput("asyncRstStart", spi_start, 0);
    checkOutput("asyncRstOp", spi_op, 0);
    checkOutput("asyncRstSize", spi_size, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    startBefore = startCount;
    validBefore = validCount;
    @(negedge clk);
    spi_data_out = 8'h00;
    spi_wr       = 1'b1;
    spi_done     = 1'b1;
    @(negedge clk);
    spi_wr   = 1'b0;
    spi_done = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("postRstNoValid", validCount - validBefore, 0);
    checkOutput("postRstNoStart", startCount - startBefore, 0);
    checkOutput("postRstIdle", busy, 0);

    v17 = '{idx: 6'd17, arg: 32'h00000200, crcByte: crc7Ref(6'd17, 32'h00000200),
            resp: 64'hFFFF00FFFFFFFFFF, coincide: 1'b0, expR1: 8'h00, expTimeout: 1'b0};
    applyStimulus(v17, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
